// File: rtl/stopwatch_counter_if.sv
// Control pulses into the stopwatch core and the registered time/status it reports.
interface stopwatch_counter_if;
  logic        start_stop;
  logic        clear;
  logic        lap;
  logic [14:0] ms;
  logic [6:0]  sec;
  logic [6:0]  min;
  logic [6:0]  hs;
  logic        running;
  logic        lap_active;
  logic        wrap;

  modport master (
    output start_stop, clear, lap,
    input  ms, sec, min, hs, running, lap_active, wrap
  );

  modport slave (
    input  start_stop, clear, lap,
    output ms, sec, min, hs, running, lap_active, wrap
  );
endinterface

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping core: ms prescaler, ms/sec/min/hour counters with carry,
// start/stop FSM, clear, and a lap freeze on the registered display outputs.
module stopwatch_counter #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_DIV    = CLK_FREQ_HZ / 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  stopwatch_counter_if.slave sw
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [9:0] MS_LAST = 10'd999;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  // Field 0 = seconds, 1 = minutes, 2 = hours.
  function automatic logic [6:0] hi_max(input int idx);
    hi_max = (idx == 2) ? 7'd99 : 7'd59;
  endfunction

  state_t            state_reg, state_next;
  logic [PRE_W-1:0]  pre_reg, pre_next;
  logic [9:0]        c_ms_reg, c_ms_next;
  logic [2:0][6:0]   c_hi_reg, c_hi_next;
  logic [9:0]        ms_reg, ms_next;
  logic [2:0][6:0]   hi_out_reg, hi_out_next;
  logic              lap_reg, lap_next;
  logic              wrap_reg, wrap_next;

  logic              tick;
  logic              ms_at_max;
  logic              ms_carry;
  logic [2:0]        hi_at_max;
  logic [2:0]        carry_in;

  // FSM and lap flag; lap decisions look at the state before any toggle this cycle.
  always_comb begin
    state_next = state_reg;
    lap_next   = lap_reg;
    if (sw.clear) begin
      state_next = STOPPED;
      lap_next   = 1'b0;
    end else begin
      if (sw.start_stop) begin
        state_next = (state_reg == RUNNING) ? STOPPED : RUNNING;
      end
      if (sw.lap) begin
        lap_next = (state_reg == RUNNING) ? ~lap_reg : 1'b0;
      end
    end
  end

  assign tick      = (state_reg == RUNNING) && (pre_reg == PRE_LAST);
  assign ms_at_max = (c_ms_reg == MS_LAST);
  assign ms_carry  = tick && ms_at_max;

  // Prescaler holds while stopped so a paused partial millisecond is kept.
  always_comb begin
    pre_next = pre_reg;
    if (sw.clear || tick) begin
      pre_next = '0;
    end else if (state_reg == RUNNING) begin
      pre_next = pre_reg + PRE_W'(1);
    end
  end

  always_comb begin
    c_ms_next = c_ms_reg;
    if (sw.clear) begin
      c_ms_next = '0;
    end else if (tick) begin
      c_ms_next = ms_at_max ? 10'd0 : c_ms_reg + 10'd1;
    end
  end

  // A higher field advances when the ms field carries and every field below it is at its limit.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_hi_field
      localparam logic [2:0] LOWER = 3'((1 << gi) - 1);

      assign hi_at_max[gi] = (c_hi_reg[gi] == hi_max(gi));
      assign carry_in[gi]  = ms_carry && ((hi_at_max & LOWER) == LOWER);

      always_comb begin
        c_hi_next[gi] = c_hi_reg[gi];
        if (sw.clear) begin
          c_hi_next[gi] = '0;
        end else if (carry_in[gi]) begin
          c_hi_next[gi] = hi_at_max[gi] ? 7'd0 : c_hi_reg[gi] + 7'd1;
        end
      end

      always_comb begin
        hi_out_next[gi] = hi_out_reg[gi];
        if (sw.clear) begin
          hi_out_next[gi] = '0;
        end else if (!lap_reg) begin
          hi_out_next[gi] = c_hi_reg[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    ms_next = ms_reg;
    if (sw.clear) begin
      ms_next = '0;
    end else if (!lap_reg) begin
      ms_next = c_ms_reg;
    end
  end

  assign wrap_next = ms_carry && (&hi_at_max) && !sw.clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= STOPPED;
      pre_reg    <= '0;
      c_ms_reg   <= '0;
      c_hi_reg   <= '0;
      ms_reg     <= '0;
      hi_out_reg <= '0;
      lap_reg    <= 1'b0;
      wrap_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pre_reg    <= pre_next;
      c_ms_reg   <= c_ms_next;
      c_hi_reg   <= c_hi_next;
      ms_reg     <= ms_next;
      hi_out_reg <= hi_out_next;
      lap_reg    <= lap_next;
      wrap_reg   <= wrap_next;
    end
  end

  assign sw.ms         = {5'd0, ms_reg};
  assign sw.sec        = hi_out_reg[0];
  assign sw.min        = hi_out_reg[1];
  assign sw.hs         = hi_out_reg[2];
  assign sw.running    = (state_reg == RUNNING);
  assign sw.lap_active = lap_reg;
  assign sw.wrap       = wrap_reg;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: directed scenarios plus random pulses, checked every cycle
// against a model that tracks elapsed time as a single millisecond count.
module tb_stopwatch_counter;

  localparam int TICK_DIV = 10;
  localparam int unsigned MS_MAX = 100 * 3600 * 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  stopwatch_counter_if sw_if ();

  stopwatch_counter #(.TICK_DIV(TICK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw_if)
  );

  always #5 clk = ~clk;

  // Model: elapsed time in ms, prescaler clock count, mode flags, displayed snapshot.
  int unsigned m_total, m_pre, m_disp;
  bit          m_run, m_lap, m_wrap;

  task automatic model_reset();
    m_total = 0; m_pre = 0; m_disp = 0;
    m_run = 0; m_lap = 0; m_wrap = 0;
  endtask

  task automatic model_edge(input bit ss, input bit cl, input bit lp);
    bit tick;
    tick = m_run && (m_pre == TICK_DIV - 1);
    if (cl) begin
      m_total = 0; m_pre = 0; m_disp = 0;
      m_run = 0; m_lap = 0; m_wrap = 0;
    end else begin
      m_wrap = tick && (m_total == MS_MAX - 1);
      if (!m_lap) m_disp = m_total;
      if (tick) begin
        m_total = (m_total + 1) % MS_MAX;
        m_pre = 0;
      end else if (m_run) begin
        m_pre = m_pre + 1;
      end
      if (lp) m_lap = m_run ? !m_lap : 1'b0;
      if (ss) m_run = !m_run;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ms",         32'(sw_if.ms),         m_disp % 1000);
    chk("sec",        32'(sw_if.sec),        (m_disp / 1000) % 60);
    chk("min",        32'(sw_if.min),        (m_disp / 60000) % 60);
    chk("hs",         32'(sw_if.hs),         m_disp / 3600000);
    chk("running",    32'(sw_if.running),    32'(m_run));
    chk("lap_active", 32'(sw_if.lap_active), 32'(m_lap));
    chk("wrap",       32'(sw_if.wrap),       32'(m_wrap));
  endtask

  // One clock: drive pulses, step model at the edge, sample 1 time unit later.
  task automatic cyc(input bit ss, input bit cl, input bit lp);
    sw_if.start_stop = ss;
    sw_if.clear      = cl;
    sw_if.lap        = lp;
    @(posedge clk);
    model_edge(ss, cl, lp);
    #1;
    sw_if.start_stop = 1'b0;
    sw_if.clear      = 1'b0;
    sw_if.lap        = 1'b0;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int wrap_seen;
    int guard;
    sw_if.start_stop = 1'b0;
    sw_if.clear      = 1'b0;
    sw_if.lap        = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ms", 32'(sw_if.ms), 0);
    chk("rst_running", 32'(sw_if.running), 0);
    check_all();
    rst_n = 1'b1;

    // 1: 10000 clocks of running = 1000 ms, visible one clock later
    cyc(1, 0, 0);
    repeat (10001) cyc(0, 0, 0);
    chk("t1_sec", 32'(sw_if.sec), 1);
    chk("t1_ms", 32'(sw_if.ms), 0);
    chk("t1_running", 32'(sw_if.running), 1);

    // 2: preload 99:59:59.998 while stopped, then roll over
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    force dut.c_ms_reg = 10'd998;
    force dut.c_hi_reg = {7'd99, 7'd59, 7'd59};
    m_total = MS_MAX - 2;
    cyc(0, 0, 0);
    release dut.c_ms_reg;
    release dut.c_hi_reg;
    cyc(0, 0, 0);
    chk("t2_pre_hs", 32'(sw_if.hs), 99);
    wrap_seen = 0;
    cyc(1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0);
      wrap_seen += int'(sw_if.wrap);
    end
    chk("t2_wrap_count", 32'(wrap_seen), 1);
    chk("t2_hs_after", 32'(sw_if.hs), 0);

    // 3: pause keeps the partial millisecond
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    repeat (25) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (100) cyc(0, 0, 0);
    chk("t3_stopped_ms", 32'(sw_if.ms), 2);
    cyc(1, 0, 0);
    repeat (5) cyc(0, 0, 0);
    chk("t3_ms", 32'(sw_if.ms), 3);

    // 4: lap freeze at ms=5, then release
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    guard = 0;
    while (sw_if.ms != 15'd5 && guard < 200) begin
      cyc(0, 0, 0);
      guard++;
    end
    chk("t4_reach5_timeout", 32'(guard < 200), 1);
    cyc(0, 0, 1);
    repeat (50) cyc(0, 0, 0);
    chk("t4_frozen_ms", 32'(sw_if.ms), 5);
    chk("t4_lap_active", 32'(sw_if.lap_active), 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("t4_released_ms", 32'(sw_if.ms), 10);

    // 5: clear + start_stop while running with lap frozen
    cyc(0, 0, 1);
    repeat (3) cyc(0, 0, 0);
    cyc(1, 1, 0);
    chk("t5_running", 32'(sw_if.running), 0);
    chk("t5_lap", 32'(sw_if.lap_active), 0);
    chk("t5_ms", 32'(sw_if.ms), 0);

    // 6: asynchronous reset between clock edges
    cyc(1, 0, 0);
    repeat (1037) cyc(0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_ms", 32'(sw_if.ms), 0);
    chk("t6_sec", 32'(sw_if.sec), 0);
    chk("t6_running", 32'(sw_if.running), 0);
    check_all();
    #2;
    rst_n = 1'b1;

    // Random pulses, including simultaneous ones
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0, $urandom_range(0, 29) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
